// File: rtl/add6_chain_ctrl.sv
// add6_chain_ctrl
//   Sequential wrapper that performs a WORDS x 6-bit wide addition by walking
//   6-bit slices, LSB first, through an external combinational 6-bit adder,
//   one slice per clock.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b, in_cin sampled on accept
//   add_a/add_b/add_cin   registered drive to the 6-bit adder (zero outside RUN)
//   add_sum/add_cout      adder result, combinational from add_a/add_b/add_cin
//   out_valid/out_ready   result handshake; out_sum, out_cout held while in DONE
//   busy                  high while slices are being processed

module add6_chain_ctrl #(
    parameter int unsigned WORDS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*WORDS-1:0]   in_a,
    input  logic [6*WORDS-1:0]   in_b,
    input  logic                 in_cin,
    output logic [5:0]           add_a,
    output logic [5:0]           add_b,
    output logic                 add_cin,
    input  logic [5:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 busy
);

    localparam int unsigned W  = 6 * WORDS;
    localparam int unsigned CW = $clog2(WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    carry_d    = in_cin;
                    cout_d     = 1'b0;
                    res_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                // Sum slices enter at the top so the LSB slice ends up at bit 0.
                res_d   = {add_sum, res_q[W-1:6]};
                // Zero fill: after WORDS shifts the operand registers are empty,
                // which keeps add_a/add_b quiet in DONE and IDLE without muxing.
                a_d     = {6'b0, a_q[W-1:6]};
                b_d     = {6'b0, b_q[W-1:6]};
                carry_d = add_cout;
                if (cnt_q == CW'(WORDS - 1)) begin
                    // Final carry moves to the output; add_cin goes quiet.
                    cout_d      = add_cout;
                    carry_d     = 1'b0;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                a_d         = '0;
                b_d         = '0;
                carry_d     = 1'b0;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Adder pins come straight from flops so the adder sees glitch-free inputs.
    assign add_a     = a_q[5:0];
    assign add_b     = b_q[5:0];
    assign add_cin   = carry_q;
    assign out_sum   = res_q;
    assign out_cout  = cout_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add6_chain_ctrl.sv
// Testbench for add6_chain_ctrl: three instances (WORDS = 2, 6, 16), each
// paired with a behavioural 6-bit adder. Directed tests run on WORDS = 6.

module tb_add6_chain_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [95:0] in_a      [3];
    logic [95:0] in_b      [3];
    logic        in_cin    [3];
    logic [5:0]  add_a     [3];
    logic [5:0]  add_b     [3];
    logic        add_cin   [3];
    logic [5:0]  add_sum   [3];
    logic        add_cout  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [95:0] out_sum   [3];
    logic        out_cout  [3];
    logic        busy      [3];

    int n_cmp;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 2 : ((g == 1) ? 6 : 16);
        logic [6*WS-1:0] os;

        add6_chain_ctrl #(.WORDS(WS)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_a      (in_a[g][6*WS-1:0]),
            .in_b      (in_b[g][6*WS-1:0]),
            .in_cin    (in_cin[g]),
            .add_a     (add_a[g]),
            .add_b     (add_b[g]),
            .add_cin   (add_cin[g]),
            .add_sum   (add_sum[g]),
            .add_cout  (add_cout[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_sum   (os),
            .out_cout  (out_cout[g]),
            .busy      (busy[g])
        );

        assign out_sum[g] = 96'(os);
        assign {add_cout[g], add_sum[g]} = 7'(add_a[g]) + 7'(add_b[g]) + 7'(add_cin[g]);
    end

    function automatic int words_of(input int sel);
        return (sel == 0) ? 2 : ((sel == 1) ? 6 : 16);
    endfunction

    // Caller sits on a negedge; accept happens on the following posedge and the
    // task returns on the negedge after it (RUN cycle 1).
    task automatic start_op(input int sel, input logic [95:0] a, input logic [95:0] b,
                            input logic cin);
        in_valid[sel] = 1'b1;
        in_a[sel]     = a;
        in_b[sel]     = b;
        in_cin[sel]   = cin;
        @(negedge clk);
        in_valid[sel] = 1'b0;
    endtask

    // e = edges after accept until out_valid seen; tr[k] = add_cin in RUN cycle k+1.
    task automatic wait_done(input int sel, output int e, output logic [15:0] tr);
        e  = 0;
        tr = '0;
        while (out_valid[sel] !== 1'b1 && e < 40) begin
            if (e < 16) tr[e] = add_cin[sel];
            @(negedge clk);
            e++;
        end
    endtask

    task automatic release_op(input int sel);
        out_ready[sel] = 1'b1;
        @(negedge clk);
        out_ready[sel] = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 ||
                out_sum[i] !== 96'h0 || out_cout[i] !== 1'b0 || add_a[i] !== 6'h0 ||
                add_b[i] !== 6'h0 || add_cin[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s[%0d]: rdy=%b vld=%b busy=%b sum=%h cout=%b a=%h b=%h cin=%b, want 1 0 0 0 0 0 0 0",
                         name, i, in_ready[i], out_valid[i], busy[i], out_sum[i], out_cout[i],
                         add_a[i], add_b[i], add_cin[i]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_vals("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_idle");
    endtask

    task automatic test_simple();
        int          e;
        logic [15:0] tr;
        start_op(1, 96'h000000005, 96'h000000003, 1'b0);
        n_cmp++;
        if (busy[1] !== 1'b1 || in_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL simple_run_flags: busy=%b in_ready=%b, want 1 0", busy[1], in_ready[1]);
        end
        wait_done(1, e, tr);
        n_cmp++;
        if (e !== 6) begin
            n_fail++;
            $display("FAIL simple_latency: got %0d edges, want 6", e);
        end
        n_cmp++;
        if (out_sum[1] !== 96'h000000008 || out_cout[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL simple_sum: got %h/%b, want 000000008/0", out_sum[1], out_cout[1]);
        end
        release_op(1);
    endtask

    task automatic test_ripple();
        int          e;
        logic [15:0] tr;
        start_op(1, 96'hFFFFFFFFF, 96'h000000001, 1'b0);
        wait_done(1, e, tr);
        n_cmp++;
        if (out_sum[1] !== 96'h0 || out_cout[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_sum: got %h/%b, want 000000000/1", out_sum[1], out_cout[1]);
        end
        n_cmp++;
        if (tr[5:0] !== 6'b111110) begin
            n_fail++;
            $display("FAIL ripple_add_cin: got %b, want 111110", tr[5:0]);
        end
        release_op(1);
    endtask

    task automatic test_all_ones();
        int          e;
        logic [15:0] tr;
        start_op(1, 96'hFFFFFFFFF, 96'hFFFFFFFFF, 1'b1);
        wait_done(1, e, tr);
        n_cmp++;
        if (out_sum[1] !== 96'hFFFFFFFFF || out_cout[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL all_ones_sum: got %h/%b, want FFFFFFFFF/1", out_sum[1], out_cout[1]);
        end
        release_op(1);
    endtask

    task automatic test_backpressure();
        int          e;
        logic [15:0] tr;
        start_op(1, 96'h00000ABCD, 96'h000001111, 1'b0);
        wait_done(1, e, tr);
        for (int k = 0; k < 10; k++) begin
            in_valid[1] = (k % 2 == 0);
            in_a[1]     = 96'h000000777;
            in_b[1]     = 96'h000000111;
            @(negedge clk);
            n_cmp++;
            if (out_valid[1] !== 1'b1 || out_sum[1] !== 96'h00000BCDE || in_ready[1] !== 1'b0 ||
                add_a[1] !== 6'h0 || add_b[1] !== 6'h0 || add_cin[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: vld=%b sum=%h rdy=%b a=%h b=%h cin=%b, want 1 00000BCDE 0 0 0 0",
                         k, out_valid[1], out_sum[1], in_ready[1], add_a[1], add_b[1], add_cin[1]);
            end
        end
        in_valid[1] = 1'b0;
        release_op(1);
        n_cmp++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: rdy=%b vld=%b busy=%b, want 1 0 0",
                     in_ready[1], out_valid[1], busy[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (busy[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_queue: busy=%b rdy=%b, want 0 1", busy[1], in_ready[1]);
        end
    endtask

    task automatic test_mid_reset();
        int          e;
        logic [15:0] tr;
        start_op(1, 96'hFFFFFFFFF, 96'h000000001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1, 96'h123456789, 96'h111111111, 1'b0);
        wait_done(1, e, tr);
        n_cmp++;
        if (out_sum[1] !== 96'h23456789A || out_cout[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_sum: got %h/%b, want 23456789A/0", out_sum[1], out_cout[1]);
        end
        release_op(1);
    endtask

    task automatic test_back_to_back();
        int          sel, ws, w, e, stall;
        logic [15:0] tr;
        logic [95:0] a, b, mask, exp_sum;
        logic [96:0] full;
        logic        cin, exp_cout;
        for (int n = 0; n < 200; n++) begin
            sel  = $urandom_range(0, 2);
            ws   = words_of(sel);
            w    = 6 * ws;
            mask = (w == 96) ? '1 : ((96'(1) << w) - 96'(1));
            a    = {$urandom, $urandom, $urandom} & mask;
            b    = {$urandom, $urandom, $urandom} & mask;
            cin  = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + 97'(cin);
            exp_sum  = full[95:0] & mask;
            exp_cout = full[w];
            start_op(sel, a, b, cin);
            wait_done(sel, e, tr);
            n_cmp++;
            if (e !== ws) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d edges, want %0d", n, e, ws);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            n_cmp++;
            if (out_sum[sel] !== exp_sum || out_cout[sel] !== exp_cout) begin
                n_fail++;
                $display("FAIL b2b_sum[%0d] W%0d: got %h/%b, want %h/%b", n, ws,
                         out_sum[sel], out_cout[sel], exp_sum, exp_cout);
            end
            release_op(sel);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_a[i]      = '0;
            in_b[i]      = '0;
            in_cin[i]    = 1'b0;
            out_ready[i] = 1'b0;
        end
        test_reset();
        test_simple();
        test_ripple();
        test_all_ones();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/add6_chain_ctrl.md
Name: add6_chain_ctrl

Overview:
- Sequential wrapper that performs wide (WORDS x 6-bit) addition by iterating slices through the existing 6-bit combinational adder, one slice per clock.
- Accepts wide operands over a valid/ready handshake and drives the adder's A, B and carry-in pins.
- Captures the adder's 6-bit sum and carry-out, and feeds the carry-out back as the next slice's carry-in.
- Sits directly upstream and downstream of the 6-bit adder in the arithmetic datapath.

Parameters:
- WORDS, 6, number of 6-bit slices per operation; operand width W = 6*WORDS (default 36). Legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  W  operand A, unsigned.
- in_b  input  W  operand B, unsigned.
- in_cin  input  1  initial carry-in.
- add_a  output  6  slice of A driven to the 6-bit adder (bit 0 = LSB).
- add_b  output  6  slice of B driven to the 6-bit adder.
- add_cin  output  1  carry-in driven to the 6-bit adder.
- add_sum  input  6  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W  wide sum, (in_a + in_b + in_cin) mod 2^W.
- out_cout  output  1  final carry-out.
- busy  output  1  high in RUN.

Behaviour:
- Reset is asynchronous, active-low. While rst_n = 0 the block is in IDLE and all outputs are held at their reset values.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_sum = 0, out_cout = 0, add_a = 0, add_b = 0, add_cin = 0, slice counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, load the A/B shift registers from in_a/in_b and the carry register from in_cin, clear the counter and result register, and go to RUN.
  - in_a, in_b and in_cin are sampled only on that accept edge.
- RUN:
  - in_ready = 0, busy = 1.
  - add_a and add_b equal the low 6 bits of the A/B shift registers; add_cin equals the carry register. All three are derived from registers only and are glitch-free.
  - Each edge:
    - shift add_sum into the top 6 bits of the result register; the result shifts right by 6.
    - shift the A/B registers right by 6.
    - carry register <= add_cout.
    - counter += 1.
  - On the edge where counter == WORDS-1, go to DONE. RUN therefore lasts exactly WORDS cycles.
- DONE:
  - out_valid = 1; out_sum and out_cout (the last captured carry) are stable.
  - add_a, add_b and add_cin are driven to 0.
  - On an edge with out_ready = 1, go to IDLE and drop out_valid.
  - There is no same-cycle turnaround: in_ready is 0 in DONE.
- Latency: out_valid rises WORDS edges after the accept edge. Throughput is one operation per WORDS+2 cycles when out_ready is held at 1.
- Backpressure: with out_ready = 0, DONE is held indefinitely and outputs stay stable.
- add_a/add_b/add_cin are 0 in IDLE and DONE, so the adder sees quiet inputs outside RUN.
- In RUN and DONE, in_valid is ignored; requests are not queued.
- Reset asserted mid-RUN or in DONE: the operation is discarded, with no partial result and no out_valid pulse. The block restarts in IDLE.
- The counter is ceil(log2(WORDS)) bits wide and never wraps within one operation.
- Arithmetic is unsigned. Overflow appears only on out_cout; out_sum wraps modulo 2^W.

Test Plan:
- WORDS = 6, reset, then in_a = 36'h000000005, in_b = 36'h000000003, in_cin = 0 -> out_valid rises 6 edges after accept; out_sum = 36'h000000008, out_cout = 0.
- in_a = 36'hFFFFFFFFF, in_b = 36'h000000001, in_cin = 0 -> carry ripples through all 6 slices; out_sum = 0, out_cout = 1; add_cin = 1 in RUN cycles 2-6.
- in_a = 36'hFFFFFFFFF, in_b = 36'hFFFFFFFFF, in_cin = 1 -> out_sum = 36'hFFFFFFFFF, out_cout = 1.
- Hold out_ready = 0 for 10 cycles in DONE while pulsing in_valid -> out_valid and out_sum stay stable, in_ready = 0, no second request accepted. Release out_ready -> back to IDLE after 1 edge.
- Assert rst_n = 0 during RUN cycle 3 -> all outputs at reset values immediately (asynchronous). After release, a new request 36'h123456789 + 36'h111111111 gives out_sum = 36'h23456789A.
- 200 random back-to-back operations with a behavioural 6-bit adder model, random out_ready stalls and random WORDS in {2, 6, 16} -> every result equals a reference wide add; latency is exactly WORDS edges.
